// File: rtl/gmii_tx_framer.sv
// GMII transmit framer.
// Pulls frame bytes from a 9-bit TX FIFO (bit 8 = frame byte, 0 = gap/terminator word),
// wraps them in preamble/SFD, optionally pads them to 60 bytes, appends the Ethernet FCS
// and enforces an inter-frame gap.
// Ports:
//   gmii_tx_clk  - clock, all logic on its rising edge
//   sys_rst      - synchronous active-high reset
//   dout, empty  - TX FIFO read data (valid the cycle after rd_en) and empty flag
//   rd_en        - FIFO read strobe
//   gmii_tx_en, gmii_txd - GMII transmit enable and data (registered)
//   tx_underrun  - one-cycle pulse when the FIFO runs dry mid-frame
module gmii_tx_framer #(
    parameter logic [3:0] IFG    = 4'd12,
    parameter logic       PAD_EN = 1'b1
) (
    input  logic       gmii_tx_clk,
    input  logic       sys_rst,
    input  logic [8:0] dout,
    input  logic       empty,
    output logic       rd_en,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic       tx_underrun
);

    typedef enum logic [2:0] {IDLE, FETCH, PREAMBLE, SFD, DATA, PAD, FCS, GAP} state_t;

    state_t      state;
    logic        rd_q;        // a FIFO word is presented on dout this cycle
    logic        bad;
    logic        flush;       // drop the rest of a frame cut short by reset
    logic [7:0]  first_byte;
    logic [10:0] byte_cnt;
    logic [3:0]  cnt;         // shared preamble / FCS / gap counter
    logic [31:0] crc;
    logic [31:0] fcs_sr;

    logic        underrun_now;
    logic        pad_more;
    logic [31:0] fcs_word;
    logic [10:0] byte_cnt_inc;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // rd_en is combinational on empty so it can never fire on an empty FIFO.
    // In DATA, only read ahead while the word on dout is a frame byte, so the
    // terminator is never overrun into the next frame.
    always_comb begin
        rd_en = 1'b0;
        if (!sys_rst && !empty) begin
            case (state)
                IDLE:    rd_en = 1'b1;
                SFD:     rd_en = 1'b1;
                DATA:    rd_en = rd_q && dout[8];
                default: rd_en = 1'b0;
            endcase
        end
    end

    always_comb begin
        underrun_now = (state == DATA) && !rd_q;
        pad_more     = PAD_EN && (byte_cnt < 11'd60);
        // A bad frame sends the raw CRC, which is the inverse of the correct FCS.
        fcs_word     = (bad || underrun_now) ? crc : ~crc;
        byte_cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    end

    always_ff @(posedge gmii_tx_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            gmii_tx_en  <= 1'b0;
            gmii_txd    <= 8'h00;
            tx_underrun <= 1'b0;
            rd_q        <= 1'b0;
            bad         <= 1'b0;
            first_byte  <= 8'h00;
            byte_cnt    <= 11'd0;
            cnt         <= 4'd0;
            crc         <= 32'hFFFF_FFFF;
            fcs_sr      <= 32'd0;
            // Frame in flight and its terminator not yet consumed: skip its remainder.
            flush       <= (flush || (state inside {FETCH, PREAMBLE, SFD, DATA}))
                           && !(rd_q && !dout[8]);
        end else begin
            rd_q        <= rd_en;
            tx_underrun <= 1'b0;
            case (state)
                IDLE: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                    if (rd_en) state <= FETCH;
                end
                FETCH: begin
                    if (!dout[8]) begin
                        flush <= 1'b0;
                        state <= IDLE;
                    end else if (flush) begin
                        state <= IDLE;
                    end else begin
                        first_byte <= dout[7:0];
                        gmii_tx_en <= 1'b1;
                        gmii_txd   <= 8'h55;
                        cnt        <= 4'd0;
                        byte_cnt   <= 11'd0;
                        crc        <= 32'hFFFF_FFFF;
                        bad        <= 1'b0;
                        state      <= PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    if (cnt == 4'd6) begin
                        gmii_txd <= 8'hD5;
                        state    <= SFD;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SFD: begin
                    gmii_txd <= first_byte;
                    crc      <= crc_next(crc, first_byte);
                    byte_cnt <= 11'd1;
                    state    <= DATA;
                end
                DATA, PAD: begin
                    if (state == DATA && rd_q && dout[8]) begin
                        gmii_txd <= dout[7:0];
                        crc      <= crc_next(crc, dout[7:0]);
                        byte_cnt <= byte_cnt_inc;
                    end else begin
                        if (underrun_now) begin
                            tx_underrun <= 1'b1;
                            bad         <= 1'b1;
                        end
                        if (pad_more) begin
                            gmii_txd <= 8'h00;
                            crc      <= crc_next(crc, 8'h00);
                            byte_cnt <= byte_cnt_inc;
                            state    <= PAD;
                        end else begin
                            gmii_txd <= fcs_word[7:0];
                            fcs_sr   <= {8'h00, fcs_word[31:8]};
                            cnt      <= 4'd0;
                            state    <= FCS;
                        end
                    end
                end
                FCS: begin
                    if (cnt == 4'd3) begin
                        gmii_tx_en <= 1'b0;
                        gmii_txd   <= 8'h00;
                        cnt        <= 4'd0;
                        state      <= (IFG == 4'd0) ? IDLE : GAP;
                    end else begin
                        gmii_txd <= fcs_sr[7:0];
                        fcs_sr   <= {8'h00, fcs_sr[31:8]};
                        cnt      <= cnt + 4'd1;
                    end
                end
                GAP: begin
                    if (cnt == IFG - 4'd1) state <= IDLE;
                    else cnt <= cnt + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gmii_tx_framer.md
GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

Interface
REQ-001 SHALL have parameter IFG, default 4'd12: minimum idle cycles (gmii_tx_en low) between frames.
REQ-002 SHALL have parameter PAD_EN, default 1'b1: 1 = pad payload to 60 bytes with 0x00.
REQ-003 SHALL have port gmii_tx_clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port dout, input, 9 bits, from the TX FIFO: bit 8 = 1 is a frame byte, bit 8 = 0 is a gap/terminator word, bits 7:0 = byte.
REQ-006 SHALL have port empty, input, 1 bit: TX FIFO empty.
REQ-007 SHALL have port rd_en, output, 1 bit: FIFO read strobe; dout is valid the cycle after rd_en.
REQ-008 SHALL have port gmii_tx_en, output, 1 bit: GMII transmit enable.
REQ-009 SHALL have port gmii_txd, output, 8 bits: GMII transmit data.
REQ-010 SHALL have port tx_underrun, output, 1 bit: one-cycle pulse on mid-frame FIFO underrun.

Function
REQ-011 SHALL implement states IDLE, FETCH, PREAMBLE, SFD, DATA, PAD, FCS, GAP.
REQ-012 IDLE: SHALL assert rd_en when !empty and go to FETCH; SHALL hold rd_en low when empty.
REQ-013 FETCH: dout[8]=0 SHALL be discarded and return to IDLE (rd_en again if !empty); dout[8]=1 SHALL latch the byte and go to PREAMBLE.
REQ-014 PREAMBLE SHALL drive gmii_tx_en=1, gmii_txd=0x55 for exactly 7 cycles; SFD SHALL drive 0xD5 for 1 cycle.
REQ-015 DATA SHALL output one payload byte per cycle with no bubbles, reading ahead from the FIFO so the first payload byte follows SFD directly.
REQ-016 A read word with dout[8]=0 in DATA SHALL end the payload; that word is consumed, not transmitted.
REQ-017 FIFO empty when the next payload byte is needed SHALL end the payload, pulse tx_underrun for 1 cycle, and mark the frame bad.
REQ-018 PAD (PAD_EN=1, payload < 60 bytes) SHALL emit 0x00 until payload+pad = 60; PAD_EN=0 SHALL skip PAD.
REQ-019 Byte counter SHALL be 11 bits and saturate at 2047; no maximum frame length is enforced.
REQ-020 CRC SHALL be Ethernet CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) over payload+pad only.
REQ-021 FCS SHALL emit ~CRC over 4 cycles, least-significant byte first; a bad frame (REQ-017) SHALL emit the bitwise inverse of the correct FCS.
REQ-022 GAP SHALL hold gmii_tx_en=0, gmii_txd=0x00, rd_en=0 for exactly IFG cycles, then enter IDLE.
REQ-023 gmii_tx_en SHALL rise exactly 2 cycles after the IDLE rd_en that returns the first frame byte.
REQ-024 With the next frame already queued, the gap between frames SHALL be exactly IFG+2 cycles.
REQ-025 rd_en SHALL never be asserted while empty=1.
REQ-026 Outside PREAMBLE/SFD/DATA/PAD/FCS, gmii_tx_en SHALL be 0 and gmii_txd SHALL be 0x00.

Reset
REQ-027 With sys_rst=1 at a clock edge, the next cycle SHALL have state=IDLE, gmii_tx_en=0, gmii_txd=0x00, rd_en=0, tx_underrun=0, counters and CRC cleared.
REQ-028 Reset mid-frame SHALL truncate the frame immediately with no FCS; the partially read frame is not resumed.

Verification
REQ-029 PAD_EN=0; FIFO holds 0x131..0x139 ("123456789") then 0x000 -> txd 7x55, D5, 31..39, 26 39 F4 CB; gmii_tx_en high 21 cycles.
REQ-030 PAD_EN=1; 1-byte frame 0x1AA then 0x000 -> 8 preamble/SFD bytes, AA, 59x00, 4 FCS bytes; gmii_tx_en high 72 cycles; FCS matches model.
REQ-031 Two back-to-back 64-byte frames queued, IFG=12 -> gmii_tx_en low exactly 14 cycles between frames.
REQ-032 FIFO goes empty after 10 of 20 payload bytes -> tx_underrun pulses once; 10 bytes + 50 pad + inverted FCS sent.
REQ-033 Leading gap words 0x000 x3 before a frame -> all discarded, no tx_en; frame then sent normally.
REQ-034 sys_rst asserted during the 5th payload byte -> gmii_tx_en=0 the next cycle; after release, the next queued frame is sent correctly.
